// File: rtl/core_exec_sequencer_if.sv
// Instruction-fetch and data-memory bus bundle between the sequencer and its memories.
// Valid/ready: a request transfers on the cycle req_valid & req_ready are both high; the
// requester holds req_valid until then. resp_err is meaningful only while resp_valid is high.
interface core_exec_sequencer_if;
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_resp_valid;
  logic ifu_resp_err;
  logic lsu_req_valid;
  logic lsu_req_ready;
  logic lsu_resp_valid;
  logic lsu_resp_err;

  modport master (
    output ifu_req_valid,
    input  ifu_req_ready,
    input  ifu_resp_valid,
    input  ifu_resp_err,
    output lsu_req_valid,
    input  lsu_req_ready,
    input  lsu_resp_valid,
    input  lsu_resp_err
  );

  modport slave (
    input  ifu_req_valid,
    output ifu_req_ready,
    output ifu_resp_valid,
    output ifu_resp_err,
    input  lsu_req_valid,
    output lsu_req_ready,
    output lsu_resp_valid,
    output lsu_resp_err
  );
endinterface

// File: rtl/core_exec_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer for the RV32 core: gates pc and register-file updates.
// Optional macro SEQ_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module core_exec_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  core_exec_sequencer_if.master       bus,
  output logic                        inst_latch,
  input  logic                        dec_rd_wen,
  input  logic                        dec_is_load,
  input  logic                        dec_is_store,
  input  logic                        dec_is_ebreak,
  output logic                        pc_we,
  output logic                        rf_we,
  output logic                        halted,
  output logic                        bus_err,
  output logic [2:0]                  dbg_state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [63:0]                 cycle_cnt,
  output logic [63:0]                 instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IWAIT = 3'd1,
    S_EXEC  = 3'd2,
    S_MREQ  = 3'd3,
    S_MWAIT = 3'd4,
    S_HALT  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  localparam bit        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_hit;
  logic        ifu_req_valid_c;
  logic        lsu_req_valid_c;

  assign timeout_hit = TO_EN && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    to_cnt_d        = to_cnt_q;
    ifu_req_valid_c = 1'b0;
    lsu_req_valid_c = 1'b0;
    inst_latch      = 1'b0;
    pc_we           = 1'b0;
    rf_we           = 1'b0;
    halted          = 1'b0;
    bus_err         = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Fetch request stays low while reset is held even though the state already reads FETCH.
        ifu_req_valid_c = rst;
        if (bus.ifu_req_ready) begin
          state_d  = S_IWAIT;
          to_cnt_d = '0;
        end
      end
      S_IWAIT: begin
        if (bus.ifu_resp_valid) begin
          if (bus.ifu_resp_err) begin
            state_d = S_ERR;
          end else begin
            inst_latch = 1'b1;
            state_d    = S_EXEC;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_EXEC: begin
        if (dec_is_ebreak) begin
          state_d = S_HALT;
        end else if (dec_is_load || dec_is_store) begin
          state_d = S_MREQ;
        end else begin
          pc_we   = 1'b1;
          rf_we   = dec_rd_wen;
          state_d = S_FETCH;
        end
      end
      S_MREQ: begin
        lsu_req_valid_c = 1'b1;
        if (bus.lsu_req_ready) begin
          state_d  = S_MWAIT;
          to_cnt_d = '0;
        end
      end
      S_MWAIT: begin
        if (bus.lsu_resp_valid) begin
          if (bus.lsu_resp_err) begin
            state_d = S_ERR;
          end else begin
            // Stores retire here too, but only loads carry data back to the register file.
            pc_we   = 1'b1;
            rf_we   = dec_rd_wen & dec_is_load;
            state_d = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERR: begin
        bus_err = 1'b1;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  assign bus.ifu_req_valid = ifu_req_valid_c;
  assign bus.lsu_req_valid = lsu_req_valid_c;
  assign dbg_state         = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 64'd1;
    instret_cnt_d = instret_cnt_q;
    if (pc_we) begin
      instret_cnt_d = instret_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: doc/core_exec_sequencer.md
Name: core_exec_sequencer

Overview:
- Multi-cycle sequencer for the RV32 core datapath (pc register, register file, decoder, immediate extender, ALU).
- Replaces implicit single-cycle stepping: fetches each instruction over a valid/ready instruction bus and latches it into an instruction register.
- Gates pc update and register-file write; routes loads/stores through a valid/ready data bus.
- Halts on ebreak; latches a sticky error on bus error or timeout.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting for a bus response before error; 0 disables timeout; legal range 0..65535.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- ifu_req_valid  out  1  instruction fetch request
- ifu_req_ready  in  1  fetch request accepted
- ifu_resp_valid  in  1  fetch data valid
- ifu_resp_err  in  1  fetch bus error, qualified by ifu_resp_valid
- inst_latch  out  1  load instruction register this cycle
- dec_rd_wen  in  1  decoder write-enable request
- dec_is_load  in  1  decoded instruction is a load
- dec_is_store  in  1  decoded instruction is a store
- dec_is_ebreak  in  1  decoded instruction is ebreak
- lsu_req_valid  out  1  data bus request
- lsu_req_ready  in  1  data request accepted
- lsu_resp_valid  in  1  data response valid
- lsu_resp_err  in  1  data bus error, qualified by lsu_resp_valid
- pc_we  out  1  advance pc (one-cycle pulse)
- rf_we  out  1  register-file write strobe (one-cycle pulse)
- halted  out  1  core stopped on ebreak
- bus_err  out  1  sticky error flag
- cycle_cnt  out  64  cycles since reset (SEQ_PERF_CNT_EN only)
- instret_cnt  out  64  retired instructions (SEQ_PERF_CNT_EN only)

Behaviour:
- Reset (rst=0, async): state goes to FETCH and the timeout counter clears. All outputs are 0 except ifu_req_valid, which is 1 once rst is released because FETCH drives it.
- Reset mid-operation abandons any outstanding transaction; no pc_we or rf_we pulse is produced.
- States: FETCH, IWAIT, EXEC, MREQ, MWAIT, HALT, ERR. All outputs are Moore/Mealy combinational from the current state and inputs; nothing is registered beyond the state.
- FETCH:
  - ifu_req_valid=1, held until ifu_req_ready.
  - On handshake: go to IWAIT.
  - Responses are never sampled in FETCH.
- IWAIT:
  - On ifu_resp_valid & !ifu_resp_err: inst_latch=1 (same cycle), go to EXEC.
  - On ifu_resp_valid & ifu_resp_err: go to ERR.
- EXEC (decoder inputs valid this cycle). Priority is ebreak > load > store > ALU:
  - ebreak: go to HALT; no pc_we, no rf_we.
  - load, or store (load wins if both asserted): go to MREQ; no strobes.
  - otherwise: pc_we=1, rf_we=dec_rd_wen, go to FETCH.
- MREQ:
  - lsu_req_valid=1, held until lsu_req_ready.
  - On handshake: go to MWAIT.
- MWAIT:
  - On lsu_resp_valid & !lsu_resp_err: pc_we=1, rf_we=dec_rd_wen & dec_is_load (stores never write), go to FETCH.
  - On lsu_resp_valid & lsu_resp_err: go to ERR.
- Timeout:
  - 16-bit counter clears on entry to IWAIT/MWAIT and increments each cycle without a response.
  - If TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 with no response: go to ERR next cycle.
  - A response arriving in that same cycle wins over timeout.
- HALT: halted=1; absorbing until reset.
- ERR: bus_err=1; absorbing until reset; halted=0.
- Latency with zero-wait buses: ALU op = 3 cycles (FETCH, IWAIT, EXEC); load/store = 5 cycles.
- pc_we and rf_we are never asserted outside EXEC or MWAIT and never for more than one cycle per instruction.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle out of reset, including HALT/ERR; wraps at 2^64.
  - instret_cnt increments on each pc_we.
  - Both reset to 0.
- Undefined: the cycle_cnt and instret_cnt ports and their counters are absent.

Test Plan:
- Zero-wait buses, 4 ALU instrs, dec_rd_wen=1 → pc_we pulses at cycles 3, 6, 9, 12 after reset release; 4 rf_we pulses; instret_cnt=4.
- Load with lsu_req_ready delayed 2 cycles and response 3 cycles later → lsu_req_valid held 3 cycles; single pc_we and rf_we in the response cycle.
- Store with dec_rd_wen=1 → pc_we=1, rf_we=0 at response.
- TIMEOUT_CYCLES=4, ifu_resp_valid never arrives → bus_err=1 on the 5th cycle after entering IWAIT; no further ifu_req_valid.
- ebreak with dec_is_load=1 in EXEC → halted=1 next cycle; no pc_we/rf_we/lsu_req_valid.
- rst asserted in MWAIT, then released → state FETCH, ifu_req_valid=1, no strobes; late lsu_resp_valid ignored.
